alu_issue_stage: RTL and testbench

//  Issue side of the ALU operand/operation interface: decodes ALUOp/Funct3/Funct7 into the
//  4-bit ALU Operation code and selects SrcB (register or immediate). Registers
//  {SrcA, SrcB, Operation} in one valid/ready pipeline stage that feeds the combinational ALU.

---
 rtl/alu_issue_stage_if.sv | 32 +++
 rtl/alu_issue_stage.sv | 67 ++++++
 tb/tb_alu_issue_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decode-side offer and execute-side registered op of the ALU issue stage.
interface alu_issue_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int CNT_WIDTH     = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [1:0]               ALUOp;
   logic [2:0]               Funct3;
   logic [6:0]               Funct7;
   logic [DATA_WIDTH-1:0]    RD1;
   logic [DATA_WIDTH-1:0]    RD2;
   logic [DATA_WIDTH-1:0]    Imm;
   logic                     ALUSrc;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic                     Illegal;
   logic [CNT_WIDTH-1:0]     illegal_count;
   modport master (
      output in_valid, ALUOp, Funct3, Funct7, RD1, RD2, Imm, ALUSrc, flush, out_ready,
      input  in_ready, out_valid, SrcA, SrcB, Operation, Illegal, illegal_count
   );
   modport slave (
      input  in_valid, ALUOp, Funct3, Funct7, RD1, RD2, Imm, ALUSrc, flush, out_ready,
      output in_ready, out_valid, SrcA, SrcB, Operation, Illegal, illegal_count
   );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALUOp/Funct3/Funct7 into an ALU op code and registers {SrcA, SrcB, Operation}
// in one valid/ready stage, with a saturating count of undecodable ops.
module alu_issue_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int CNT_WIDTH     = 8
) (
   input logic              clk,
   input logic              rst_n,
   alu_issue_stage_if.slave bus
);
   localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'h0);
   localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'h1);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'h2);
   localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'h3);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'h8);
   localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'hF);
   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_illegal;
   logic [OPCODE_LENGTH-1:0] w_rop;
   logic [OPCODE_LENGTH-1:0] w_op;
   logic                     r_valid;
   logic                     r_illegal;
   logic [DATA_WIDTH-1:0]    r_src_a;
   logic [DATA_WIDTH-1:0]    r_src_b;
   logic [OPCODE_LENGTH-1:0] r_op;
   logic [CNT_WIDTH-1:0]     r_cnt;
   // ALUOp=00 short-circuits to ADD so unknown funct fields never reach the op code
   always_comb begin
      w_rop = (bus.Funct3 == 3'b111) ? OP_AND :
              (bus.Funct3 == 3'b110) ? OP_OR  :
              (bus.Funct3 == 3'b000) ? ((!bus.ALUOp[0] && bus.Funct7[5]) ? OP_SUB : OP_ADD) : OP_ILL;
      w_op  = (bus.ALUOp == 2'b00) ? OP_ADD :
              (bus.ALUOp == 2'b01) ? ((bus.Funct3 == 3'b000) ? OP_EQ : OP_ILL) : w_rop;
   end
   assign w_illegal  = (w_op == OP_ILL);
   assign w_in_ready = !bus.flush && (!r_valid || bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_illegal <= 1'b0;
         r_src_a   <= '0;
         r_src_b   <= '0;
         r_op      <= '0;
         r_cnt     <= '0;
      end else begin
         r_valid <= bus.flush ? 1'b0 : w_accept ? 1'b1 : bus.out_ready ? 1'b0 : r_valid;
         if (w_accept) begin
            r_src_a   <= bus.RD1;
            r_src_b   <= bus.ALUSrc ? bus.Imm : bus.RD2;
            r_op      <= w_op;
            r_illegal <= w_illegal;
            if (w_illegal && !(&r_cnt))
               r_cnt <= r_cnt + 1'b1;
         end
      end
   end
   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_valid;
   assign bus.SrcA          = r_src_a;
   assign bus.SrcB          = r_src_b;
   assign bus.Operation     = r_op;
   assign bus.Illegal       = r_illegal;
   assign bus.illegal_count = r_cnt;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based model of the issue stage;
// a second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_alu_issue_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   alu_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(8)) bus ();
   alu_issue_stage_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(2)) bus2 ();
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.ALUOp     = bus.ALUOp;
   assign bus2.Funct3    = bus.Funct3;
   assign bus2.Funct7    = bus.Funct7;
   assign bus2.RD1       = bus.RD1;
   assign bus2.RD2       = bus.RD2;
   assign bus2.Imm       = bus.Imm;
   assign bus2.ALUSrc    = bus.ALUSrc;
   assign bus2.flush     = bus.flush;
   assign bus2.out_ready = bus.out_ready;
   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        ill;
   } item_t;
   item_t q[$];
   int    m_cnt = 0;
   int    m_cnt2 = 0;
   bit    m_zero = 1'b1;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [3:0] ref_op(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
      if (a == 2'b00) return 4'h2;
      if (a == 2'b01) return (f3 == 3'b000) ? 4'h8 : 4'hF;
      case (f3)
         3'b000:  return (a == 2'b10 && f7[5]) ? 4'h3 : 4'h2;
         3'b110:  return 4'h1;
         3'b111:  return 4'h0;
         default: return 4'hF;
      endcase
   endfunction
   task automatic cyc(input bit v, input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                      input bit src, input bit fl, input bit ordy);
      item_t it;
      bit    exp_rdy;
      bit    acc;
      bus.in_valid = v; bus.ALUOp = aop; bus.Funct3 = f3; bus.Funct7 = f7;
      bus.RD1 = rd1; bus.RD2 = rd2; bus.Imm = imm; bus.ALUSrc = src;
      bus.flush = fl; bus.out_ready = ordy;
      #1;
      exp_rdy = !fl && (q.size() == 0 || ordy);
      if (rst_n) chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
      acc = v && exp_rdy;
      it.a = rd1;
      it.b = src ? imm : rd2;
      it.op = ref_op(aop, f3, f7);
      it.ill = (it.op == 4'hF);
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_cnt = 0;
         m_cnt2 = 0;
         m_zero = 1'b1;
      end else if (fl) begin
         q.delete();
      end else begin
         if (ordy && q.size() != 0) void'(q.pop_front());
         if (acc) begin
            q.push_back(it);
            m_zero = 1'b0;
            if (it.ill) begin
               if (m_cnt < 255) m_cnt++;
               if (m_cnt2 < 3) m_cnt2++;
            end
         end
      end
      #1;
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
         chk("SrcA", {32'd0, bus.SrcA}, {32'd0, q[0].a});
         chk("SrcB", {32'd0, bus.SrcB}, {32'd0, q[0].b});
         chk("Operation", {60'd0, bus.Operation}, {60'd0, q[0].op});
         chk("Illegal", {63'd0, bus.Illegal}, {63'd0, q[0].ill});
      end else if (m_zero) begin
         chk("rst_SrcA", {32'd0, bus.SrcA}, 64'd0);
         chk("rst_SrcB", {32'd0, bus.SrcB}, 64'd0);
         chk("rst_Operation", {60'd0, bus.Operation}, 64'd0);
         chk("rst_Illegal", {63'd0, bus.Illegal}, 64'd0);
      end
      chk("illegal_count", {56'd0, bus.illegal_count}, 64'(m_cnt));
      chk("illegal_count_w2", {62'd0, bus2.illegal_count}, 64'(m_cnt2));
      @(negedge clk);
   endtask
   task automatic rnd_legal(output logic [1:0] aop, output logic [2:0] f3);
      logic [2:0] legal3 [3];
      legal3 = '{3'b000, 3'b110, 3'b111};
      aop = 2'($urandom_range(0, 3));
      f3 = (aop == 2'b01) ? 3'b000 : (aop == 2'b00) ? 3'($urandom) : legal3[$urandom_range(0, 2)];
   endtask
   initial begin
      logic [1:0] aop;
      logic [2:0] f3;
      @(negedge clk);
      rst_n = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      rst_n = 1'b1;
      cyc(1, 2'b10, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0, 0, 0, 1);
      chk("t1_op_sub", {60'd0, bus.Operation}, 64'h3);
      chk("t1_srca", {32'd0, bus.SrcA}, 64'd10);
      chk("t1_srcb", {32'd0, bus.SrcB}, 64'd3);
      cyc(1, 2'b11, 3'b110, 7'b0100000, 32'd7, 32'h55, 32'hF0, 1, 0, 1);
      chk("t2_op_or", {60'd0, bus.Operation}, 64'h1);
      chk("t2_srcb_imm", {32'd0, bus.SrcB}, 64'hF0);
      cyc(1, 2'b00, 3'bxxx, 7'bxxxxxxx, 32'd1, 32'd2, 32'd3, 0, 0, 1);
      chk("xsafe_add", {60'd0, bus.Operation}, 64'h2);
      cyc(1, 2'b10, 3'b111, 7'd0, 32'hAAAA, 32'hBBBB, 32'd0, 0, 0, 1);
      for (int i = 0; i < 3; i++)
         cyc(1, 2'b10, 3'b110, 7'd0, 32'hCCCC, 32'hDDDD, 32'd0, 0, 0, 0);
      chk("t3_hold_a", {32'd0, bus.SrcA}, 64'hAAAA);
      cyc(1, 2'b10, 3'b110, 7'd0, 32'hCCCC, 32'hDDDD, 32'd0, 0, 0, 1);
      chk("t3_b_appears", {32'd0, bus.SrcA}, 64'hCCCC);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      rst_n = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++)
         cyc(1, 2'b01, 3'b001, 7'd0, 32'(i), 32'd0, 32'd0, 0, 0, 1);
      chk("t4_cnt5", {56'd0, bus.illegal_count}, 64'd5);
      chk("t4_cnt_sat3", {62'd0, bus2.illegal_count}, 64'd3);
      chk("t4_op_ill", {60'd0, bus.Operation}, 64'hF);
      cyc(1, 2'b11, 3'b000, 7'd0, 32'h11, 32'h22, 32'h33, 1, 0, 0);
      cyc(1, 2'b11, 3'b111, 7'd0, 32'h44, 32'h55, 32'h66, 0, 1, 0);
      chk("t5_flush_drop", {63'd0, bus.out_valid}, 64'd0);
      chk("t5_flush_cnt", {56'd0, bus.illegal_count}, 64'd5);
      cyc(1, 2'b10, 3'b000, 7'd0, 32'h77, 32'h88, 32'h0, 0, 0, 0);
      rst_n = 1'b0;
      cyc(1, 2'b01, 3'b010, 7'd0, 32'h99, 32'h98, 32'h0, 0, 0, 0);
      chk("t5_rst_valid", {63'd0, bus.out_valid}, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rnd_legal(aop, f3);
         cyc(1, aop, f3, 7'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 0, 1);
      end
      chk("t6_no_illegal", {56'd0, bus.illegal_count}, 64'd0);
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         cyc($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 7'($urandom),
             $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 7);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
